tl_rx_vc_buffer_reader: RTL and testbench
=========================================

TL_RX_VC_BUFFER_READER -- requirements
Module: tl_rx_vc_buffer_reader

Interface
REQ-001 Parameter DW, default 32, bits per double-word.
REQ-002 Parameter R_CTRL_BUS_WIDTH, default 5, width of the read-control bus to the VC buffer.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_hdr_empty_flag  input  1  VC header buffer empty.
REQ-006 i_data_empty_flag  input  1  VC data buffer empty.
REQ-007 i_r_tlp_hdr  input  4*DW  header at the header read pointer; DW0 = bits [127:96].
REQ-008 i_r_tlp_data  input  32*DW  data beat at the data read pointer; lowest DW = bits [31:0].
REQ-009 o_r_ctrl_bus  output  R_CTRL_BUS_WIDTH  {hdr_inc_en, data_inc_en, data_inc_value[2:0]}.
REQ-010 o_tlp_valid  output  1  transfer valid to the transaction consumer.
REQ-011 i_tlp_ready  input  1  consumer accepts the transfer.
REQ-012 o_tlp_sop / o_tlp_eop  output  1 each  first / last transfer of a TLP.
REQ-013 o_tlp_hdr  output  4*DW  header; valid while o_tlp_valid, unchanged for the whole TLP.
REQ-014 o_tlp_data  output  32*DW  data beat, passed straight from i_r_tlp_data.
REQ-015 o_tlp_dw_cnt  output  6  valid DWs in this beat (1..32), or 0 for a header-only TLP.

Function
REQ-016 Has-data = DW0[30] (Fmt[1]); length = DW0[9:0], with 0 meaning 1024 DW; the length is held in an 11-bit remaining-DW counter.
REQ-017 FSM states: IDLE and XFER.
  - IDLE -> XFER when i_hdr_empty_flag=0. On that edge, register the header, has-data and remaining-DW = length.
  - IDLE to first o_tlp_valid latency: exactly 1 cycle.
REQ-018 In XFER, o_tlp_valid=1 if has-data=0; otherwise o_tlp_valid = !i_data_empty_flag.
REQ-019 A handshake is o_tlp_valid & i_tlp_ready. While o_tlp_valid=1 and i_tlp_ready=0, all o_tlp_* outputs hold stable and no increments are issued.
REQ-020 Beat sizing: dw_this = min(remaining, 32). o_tlp_dw_cnt = dw_this. data_inc_value = ceil(dw_this/8), range 1..4, in 8-DW entries. Each TLP's data starts on an entry boundary.
REQ-021 o_tlp_sop = 1 on the first transfer of each TLP only. o_tlp_eop = 1 when remaining <= 32 or has-data = 0.
REQ-022 On a handshake with has-data:
  - assert data_inc_en for exactly that cycle;
  - remaining -= dw_this;
  - if eop, also assert hdr_inc_en in the same cycle and go to IDLE.
REQ-023 On a handshake of a header-only TLP: hdr_inc_en=1, data_inc_en=0, data_inc_value=0, go to IDLE.
REQ-024 Increment enables are single-cycle pulses tied to the handshake. data_inc_value = 0 whenever data_inc_en = 0.
REQ-025 Each TLP has one IDLE bubble cycle after its last transfer, so the header pointer is updated before the next header is sampled.
REQ-026 The data-empty flag rising mid-TLP stalls valid (REQ-018). It never aborts the TLP or alters the remaining count.

Reset
REQ-027 While i_rst=1 at a clock edge:
  - FSM goes to IDLE; counter and header register clear to 0;
  - o_tlp_valid, sop, eop, dw_cnt and o_r_ctrl_bus are 0.
REQ-028 Reset asserted mid-TLP abandons it with no further increments. Buffer pointers are not this block's responsibility.

Structure
REQ-029 Shared package tl_rx_pkg holds: FSM state typedef, ENTRY_DW=8, BEAT_DW=32, FMT_HAS_DATA_BIT=30, LENGTH_MSB=9.
REQ-030 One combinational sub-module, tl_rx_vc_beat_sizer: remaining in, dw_this / inc_value / last out.

Verification
REQ-031 Header-only MRd (DW0[30]=0) with ready=1: valid 1 cycle after hdr_empty falls; one transfer with sop=eop=1, dw_cnt=0, hdr_inc_en=1, data_inc_en=0.
REQ-032 MWr of length 5: one transfer with dw_cnt=5, data_inc_value=1, data_inc_en=hdr_inc_en=1, eop=1.
REQ-033 MWr of length 70: three transfers with dw_cnt 32/32/6, inc_value 4/4/1, sop on the first only, eop and hdr_inc_en on the third only.
REQ-034 Length field 0 (1024 DW): 32 transfers of 32 DW each, eop on the 32nd.
REQ-035 ready held low 3 cycles mid-TLP, then data_empty=1 for 2 cycles: outputs stable, no inc pulses, valid drops during empty, TLP then completes.
REQ-036 i_rst asserted during the 2nd beat of a 3-beat TLP: next cycle all outputs are 0 and state is IDLE; with hdr_empty=0, valid reasserts 1 cycle after reset is released.

Source files
------------

// File: rtl/tl_rx_pkg.sv
// Shared definitions for the TL receive path: reader FSM states, buffer geometry
// and TLP header field positions.
package tl_rx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } rxState_e;

   localparam int ENTRY_DW         = 8;
   localparam int BEAT_DW          = 32;
   localparam int FMT_HAS_DATA_BIT = 30;
   localparam int LENGTH_MSB       = 9;

   localparam int REM_W         = 11;
   localparam int DW_CNT_W      = 6;
   localparam int INC_VAL_W     = 3;
   localparam int ENTRY_SHIFT   = $clog2(ENTRY_DW);
   localparam int MAX_LENGTH_DW = 1024;

   // A zero length field encodes the maximum payload of 1024 DW.
   function automatic logic [REM_W-1:0] decodeLength(input logic [LENGTH_MSB:0] lengthField);
      return (lengthField == '0) ? REM_W'(MAX_LENGTH_DW) : REM_W'(lengthField);
   endfunction

endpackage

// File: rtl/tl_rx_vc_beat_sizer.sv
// Sizes the next data beat from the remaining DW count: DWs carried, buffer
// entries consumed and whether this is the final beat of the TLP.
module tl_rx_vc_beat_sizer
   import tl_rx_pkg::*;
(
   input  logic [REM_W-1:0]     remaining_i,
   output logic [DW_CNT_W-1:0]  dwThis_o,
   output logic [INC_VAL_W-1:0] incValue_o,
   output logic                 last_o
);

   // Entries are rounded up so every TLP's payload starts on a fresh entry.
   always_comb begin
      dwThis_o   = (remaining_i > REM_W'(BEAT_DW)) ? DW_CNT_W'(BEAT_DW)
                                                   : remaining_i[DW_CNT_W-1:0];
      incValue_o = INC_VAL_W'((dwThis_o + DW_CNT_W'(ENTRY_DW - 1)) >> ENTRY_SHIFT);
      last_o     = (remaining_i <= REM_W'(BEAT_DW));
   end

endmodule

// File: rtl/tl_rx_vc_buffer_reader.sv
// Reads TLPs out of a VC header/data buffer pair and presents them as a
// valid/ready beat stream, issuing pointer increments on each accepted beat.
module tl_rx_vc_buffer_reader
   import tl_rx_pkg::*;
#(
   parameter int DW               = 32,
   parameter int R_CTRL_BUS_WIDTH = 5
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_hdr_empty_flag,
   input  logic                        i_data_empty_flag,
   input  logic [4*DW-1:0]             i_r_tlp_hdr,
   input  logic [32*DW-1:0]            i_r_tlp_data,
   output logic [R_CTRL_BUS_WIDTH-1:0] o_r_ctrl_bus,
   output logic                        o_tlp_valid,
   input  logic                        i_tlp_ready,
   output logic                        o_tlp_sop,
   output logic                        o_tlp_eop,
   output logic [4*DW-1:0]             o_tlp_hdr,
   output logic [32*DW-1:0]            o_tlp_data,
   output logic [DW_CNT_W-1:0]         o_tlp_dw_cnt
);

   rxState_e             state_q, state_d;
   logic [4*DW-1:0]      hdr_q, hdr_d;
   logic                 hasData_q, hasData_d;
   logic [REM_W-1:0]     remaining_q, remaining_d;
   logic                 sop_q, sop_d;

   logic [DW_CNT_W-1:0]  dwThis;
   logic [INC_VAL_W-1:0] incValue;
   logic                 lastBeat;

   logic                 inXfer;
   logic                 valid;
   logic                 handshake;
   logic                 eop;
   logic                 hdrIncEn;
   logic                 dataIncEn;
   logic [INC_VAL_W-1:0] dataIncValue;

   tl_rx_vc_beat_sizer u_beatSizer (
      .remaining_i (remaining_q),
      .dwThis_o    (dwThis),
      .incValue_o  (incValue),
      .last_o      (lastBeat)
   );

   // Valid is gated by reset so a TLP abandoned by reset never issues another increment.
   always_comb begin
      inXfer       = (state_q == ST_XFER);
      valid        = inXfer && !i_rst && (!hasData_q || !i_data_empty_flag);
      handshake    = valid && i_tlp_ready;
      eop          = !hasData_q || lastBeat;
      hdrIncEn     = handshake && eop;
      dataIncEn    = handshake && hasData_q;
      dataIncValue = dataIncEn ? incValue : '0;
   end

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      hasData_d   = hasData_q;
      remaining_d = remaining_q;
      sop_d       = sop_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!i_hdr_empty_flag) begin
               state_d     = ST_XFER;
               hdr_d       = i_r_tlp_hdr;
               hasData_d   = i_r_tlp_hdr[3*DW + FMT_HAS_DATA_BIT];
               remaining_d = decodeLength(i_r_tlp_hdr[3*DW +: LENGTH_MSB + 1]);
               sop_d       = 1'b1;
            end
         end
         ST_XFER: begin
            // Returning to IDLE after the last beat gives the header pointer a cycle to settle.
            if (handshake) begin
               sop_d = 1'b0;
               if (hasData_q) begin
                  remaining_d = remaining_q - REM_W'(dwThis);
               end
               if (eop) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         hdr_q       <= '0;
         hasData_q   <= 1'b0;
         remaining_q <= '0;
         sop_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         hasData_q   <= hasData_d;
         remaining_q <= remaining_d;
         sop_q       <= sop_d;
      end
   end

   assign o_r_ctrl_bus = R_CTRL_BUS_WIDTH'({hdrIncEn, dataIncEn, dataIncValue});
   assign o_tlp_valid  = valid;
   assign o_tlp_sop    = inXfer && sop_q;
   assign o_tlp_eop    = inXfer && eop;
   assign o_tlp_hdr    = hdr_q;
   assign o_tlp_data   = i_r_tlp_data;
   assign o_tlp_dw_cnt = (inXfer && hasData_q) ? dwThis : '0;

endmodule

// File: tb/tb_tl_rx_vc_buffer_reader.sv
// Scoreboard bench for tl_rx_vc_buffer_reader; the bench also plays the VC buffer,
// advancing its header queue and data entry pointer from the DUT's increment bus.
module tb_tl_rx_vc_buffer_reader;

   localparam int DW = 32;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_hdr_empty_flag;
   logic            i_data_empty_flag;
   logic [4*DW-1:0] i_r_tlp_hdr;
   logic [32*DW-1:0] i_r_tlp_data;
   logic [4:0]      o_r_ctrl_bus;
   logic            o_tlp_valid;
   logic            i_tlp_ready;
   logic            o_tlp_sop;
   logic            o_tlp_eop;
   logic [4*DW-1:0] o_tlp_hdr;
   logic [32*DW-1:0] o_tlp_data;
   logic [5:0]      o_tlp_dw_cnt;

   typedef struct {
      logic         sop;
      logic         eop;
      logic [5:0]   dwCnt;
      logic         hdrInc;
      logic         dataInc;
      logic [2:0]   incVal;
      logic [31:0]  entry;
      logic [127:0] hdr;
   } beat_t;

   beat_t        expQ[$];
   logic [127:0] hdrQ[$];
   int unsigned  dataPtr;
   int           assertCount = 0;
   int           failCount = 0;

   always #5 i_clk = ~i_clk;

   tl_rx_vc_buffer_reader #(.DW(DW), .R_CTRL_BUS_WIDTH(5)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_hdr_empty_flag  (i_hdr_empty_flag),
      .i_data_empty_flag (i_data_empty_flag),
      .i_r_tlp_hdr       (i_r_tlp_hdr),
      .i_r_tlp_data      (i_r_tlp_data),
      .o_r_ctrl_bus      (o_r_ctrl_bus),
      .o_tlp_valid       (o_tlp_valid),
      .i_tlp_ready       (i_tlp_ready),
      .o_tlp_sop         (o_tlp_sop),
      .o_tlp_eop         (o_tlp_eop),
      .o_tlp_hdr         (o_tlp_hdr),
      .o_tlp_data        (o_tlp_data),
      .o_tlp_dw_cnt      (o_tlp_dw_cnt)
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic refreshInputs();
      i_hdr_empty_flag = (hdrQ.size() == 0);
      i_r_tlp_hdr      = (hdrQ.size() != 0) ? hdrQ[0] : '0;
      i_r_tlp_data     = '0;
      i_r_tlp_data[31:0]     = dataPtr;
      i_r_tlp_data[1023:992] = ~dataPtr;
   endtask

   // One clock: sample the increment bus at negedge, apply it to the buffer model after posedge.
   task automatic applyStimulus();
      logic       incHdr;
      logic       incData;
      logic [2:0] incVal;
      @(negedge i_clk);
      incHdr  = o_r_ctrl_bus[4];
      incData = o_r_ctrl_bus[3];
      incVal  = o_r_ctrl_bus[2:0];
      @(posedge i_clk);
      #1;
      if (incHdr && hdrQ.size() != 0) void'(hdrQ.pop_front());
      if (incData) dataPtr += incVal;
      refreshInputs();
   endtask

   task automatic pushBeat(input logic sop, input logic eop, input logic [5:0] dwCnt,
                           input logic hdrInc, input logic dataInc, input logic [2:0] incVal,
                           input logic [31:0] entry, input logic [127:0] hdr);
      beat_t b;
      b.sop = sop; b.eop = eop; b.dwCnt = dwCnt; b.hdrInc = hdrInc;
      b.dataInc = dataInc; b.incVal = incVal; b.entry = entry; b.hdr = hdr;
      expQ.push_back(b);
   endtask

   task automatic loadHeader(input logic [127:0] hdr);
      hdrQ.push_back(hdr);
      refreshInputs();
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && expQ.size() != 0; i++) applyStimulus();
      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: %0d beats still pending, expected 0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " valid"}, o_tlp_valid, 0);
      checkOutput({tag, " sop"}, o_tlp_sop, 0);
      checkOutput({tag, " eop"}, o_tlp_eop, 0);
      checkOutput({tag, " dw_cnt"}, o_tlp_dw_cnt, 0);
      checkOutput({tag, " ctrl_bus"}, o_r_ctrl_bus, 0);
      checkOutput({tag, " hdr"}, o_tlp_hdr, 0);
   endtask

   // Monitor: compares every accepted beat against the scoreboard and polices stalls.
   initial begin
      beat_t        e;
      logic         prevStall = 1'b0;
      logic         prevSop = 1'b0;
      logic         prevEop = 1'b0;
      logic [5:0]   prevDw = '0;
      logic [127:0] prevHdr = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall && o_tlp_valid) begin
               checkOutput("stall sop stable", o_tlp_sop, prevSop);
               checkOutput("stall eop stable", o_tlp_eop, prevEop);
               checkOutput("stall dw_cnt stable", o_tlp_dw_cnt, prevDw);
               checkOutput("stall hdr stable", o_tlp_hdr, prevHdr);
            end
            if (o_tlp_valid && i_tlp_ready) begin
               if (expQ.size() == 0) begin
                  assertCount++;
                  failCount++;
                  $display("[TB] FAIL unexpected transfer: got dw_cnt %0d, expected no transfer", o_tlp_dw_cnt);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat sop", o_tlp_sop, e.sop);
                  checkOutput("beat eop", o_tlp_eop, e.eop);
                  checkOutput("beat dw_cnt", o_tlp_dw_cnt, e.dwCnt);
                  checkOutput("beat hdr_inc_en", o_r_ctrl_bus[4], e.hdrInc);
                  checkOutput("beat data_inc_en", o_r_ctrl_bus[3], e.dataInc);
                  checkOutput("beat data_inc_value", o_r_ctrl_bus[2:0], e.incVal);
                  checkOutput("beat data entry", o_tlp_data[31:0], e.entry);
                  checkOutput("beat hdr", o_tlp_hdr, e.hdr);
               end
            end else begin
               checkOutput("no inc without handshake", o_r_ctrl_bus, 0);
            end
            prevStall = o_tlp_valid && !i_tlp_ready;
            prevSop   = o_tlp_sop;
            prevEop   = o_tlp_eop;
            prevDw    = o_tlp_dw_cnt;
            prevHdr   = o_tlp_hdr;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] hMrd, h5, h70, h1k, hStall, hRst;
      hMrd   = {32'h0000_0001, 32'h0000_00ff, 32'h1234_5678, 32'h0000_0000};
      h5     = {32'h4000_0005, 32'h0000_00ff, 32'h1000_0000, 32'h0000_0000};
      h70    = {32'h4000_0046, 32'h0000_00ff, 32'hcafe_0001, 32'h0000_0000};
      h1k    = {32'h4000_0000, 32'h0000_00ff, 32'h2000_0000, 32'h0000_0000};
      hStall = {32'h4000_0046, 32'h0000_01ff, 32'hcafe_0002, 32'h0000_0000};
      hRst   = {32'h4000_0046, 32'h0000_02ff, 32'hcafe_0003, 32'h0000_0000};

      i_rst = 1'b1;
      i_tlp_ready = 1'b1;
      i_data_empty_flag = 1'b0;
      dataPtr = 0;
      refreshInputs();
      applyStimulus();
      applyStimulus();
      #1;
      checkAllZero("reset");
      i_rst = 1'b0;

      $display("[TB] header-only MRd");
      pushBeat(1, 1, 0, 1, 0, 0, 0, hMrd);
      loadHeader(hMrd);
      #1;
      checkOutput("mrd valid before latency", o_tlp_valid, 0);
      applyStimulus();
      #1;
      checkOutput("mrd valid one cycle after hdr_empty falls", o_tlp_valid, 1);
      drain(20);

      $display("[TB] MWr length 5");
      pushBeat(1, 1, 5, 1, 1, 1, 0, h5);
      loadHeader(h5);
      drain(20);

      $display("[TB] MWr length 70");
      pushBeat(1, 0, 32, 0, 1, 4, 1, h70);
      pushBeat(0, 0, 32, 0, 1, 4, 5, h70);
      pushBeat(0, 1, 6, 1, 1, 1, 9, h70);
      loadHeader(h70);
      drain(20);

      $display("[TB] MWr length 1024");
      for (int i = 0; i < 32; i++) begin
         pushBeat(i == 0, i == 31, 32, i == 31, 1, 4, 10 + 4 * i, h1k);
      end
      loadHeader(h1k);
      drain(100);

      $display("[TB] backpressure and data-empty stall");
      i_tlp_ready = 1'b0;
      pushBeat(1, 0, 32, 0, 1, 4, 138, hStall);
      pushBeat(0, 0, 32, 0, 1, 4, 142, hStall);
      pushBeat(0, 1, 6, 1, 1, 1, 146, hStall);
      loadHeader(hStall);
      applyStimulus();
      i_tlp_ready = 1'b1;
      applyStimulus();
      i_tlp_ready = 1'b0;
      repeat (3) applyStimulus();
      i_tlp_ready = 1'b1;
      i_data_empty_flag = 1'b1;
      #1;
      checkOutput("valid drops on data empty", o_tlp_valid, 0);
      repeat (2) applyStimulus();
      #1;
      checkOutput("valid low while data empty", o_tlp_valid, 0);
      checkOutput("dw_cnt kept through data empty", o_tlp_dw_cnt, 32);
      i_data_empty_flag = 1'b0;
      drain(20);

      $display("[TB] reset during second beat");
      pushBeat(1, 0, 32, 0, 1, 4, 147, hRst);
      loadHeader(hRst);
      applyStimulus();
      applyStimulus();
      i_rst = 1'b1;
      applyStimulus();
      i_rst = 1'b0;
      #1;
      checkAllZero("after mid-TLP reset");
      checkOutput("no data inc during reset", dataPtr, 151);
      pushBeat(1, 0, 32, 0, 1, 4, 151, hRst);
      pushBeat(0, 0, 32, 0, 1, 4, 155, hRst);
      pushBeat(0, 1, 6, 1, 1, 1, 159, hRst);
      applyStimulus();
      #1;
      checkOutput("valid one cycle after reset release", o_tlp_valid, 1);
      drain(20);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
